// File: rtl/wb_load_scheduler.sv
// wb_load_scheduler: owns the single register-file write port of the nand_cpu core.
// Arbitrates between same-cycle ALU writebacks and in-order load responses. Keeps an
// in-order FIFO of outstanding load destinations and a per-register busy scoreboard
// that drives the issue-stall hazard.
module wb_load_scheduler #(
    parameter int unsigned DATA_W          = 16,
    parameter int unsigned REG_ADDR_W      = 3,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    // ALU writeback
    input  logic                                   alu_wb_valid,
    input  logic                                   alu_wb_use_rw,
    input  logic [REG_ADDR_W-1:0]                  alu_wb_rd,
    input  logic [DATA_W-1:0]                      alu_wb_data,
    input  logic                                   alu_wb_write_ps,
    input  logic                                   alu_wb_ps,
    output logic                                   alu_wb_ready,
    // Load issue and response
    input  logic                                   ld_issue,
    input  logic [REG_ADDR_W-1:0]                  ld_issue_rd,
    output logic                                   ld_issue_ready,
    input  logic                                   ld_rsp_valid,
    input  logic [DATA_W-1:0]                      ld_rsp_data,
    // Decode-stage source operands
    input  logic [REG_ADDR_W-1:0]                  src_a_addr,
    input  logic [REG_ADDR_W-1:0]                  src_b_addr,
    input  logic                                   src_b_used,
    output logic                                   hazard,
    // Register-file and predicate write port
    output logic                                   rf_we,
    output logic [REG_ADDR_W-1:0]                  rf_waddr,
    output logic [DATA_W-1:0]                      rf_wdata,
    output logic                                   ps_we,
    output logic                                   ps_wdata,
    // Status
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
    output logic                                   err_underflow
);

    localparam int unsigned NumRegs = 1 << REG_ADDR_W;
    localparam int unsigned PtrW    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CntW    = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [PtrW-1:0] PtrLast = PtrW'(MAX_OUTSTANDING - 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(MAX_OUTSTANDING);

    // Registered state
    logic [NumRegs-1:0]    r_busy;
    logic [REG_ADDR_W-1:0] r_fifo [MAX_OUTSTANDING];
    logic [PtrW-1:0]       r_head;
    logic [PtrW-1:0]       r_tail;
    logic [CntW-1:0]       r_count;
    logic                  r_err;

    // Combinational control
    logic                  w_load_win;
    logic                  w_alu_waw;
    logic                  w_alu_ready;
    logic                  w_issue_ready;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_underflow;
    logic [REG_ADDR_W-1:0] w_head_rd;
    logic [PtrW-1:0]       w_head_nxt;
    logic [PtrW-1:0]       w_tail_nxt;

    assign w_head_rd  = r_fifo[r_head];
    assign w_load_win = ld_rsp_valid & (r_count != '0);
    assign w_underflow = ld_rsp_valid & (r_count == '0);

    // A busy destination means an older load still owes that register a write; an ALU
    // write now would be overwritten out of order, so it is held back.
    assign w_alu_waw   = alu_wb_valid & alu_wb_use_rw & r_busy[alu_wb_rd];
    assign w_alu_ready = ~w_load_win & ~w_alu_waw;

    // Busy destinations are refused so no register ever has two loads in flight.
    assign w_issue_ready = (r_count < CntMax) & ~r_busy[ld_issue_rd];

    assign w_push = ld_issue & w_issue_ready;
    assign w_pop  = w_load_win;

    assign w_head_nxt = (r_head == PtrLast) ? '0 : r_head + PtrW'(1);
    assign w_tail_nxt = (r_tail == PtrLast) ? '0 : r_tail + PtrW'(1);

    // Write-port mux: load responses first, then ALU writeback, else all-zero
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        ps_we    = 1'b0;
        ps_wdata = 1'b0;
        if (w_load_win) begin
            rf_we    = 1'b1;
            rf_waddr = w_head_rd;
            rf_wdata = ld_rsp_data;
        end else if (w_alu_ready) begin
            if (alu_wb_valid & alu_wb_use_rw) begin
                rf_we    = 1'b1;
                rf_waddr = alu_wb_rd;
                rf_wdata = alu_wb_data;
            end
            if (alu_wb_valid & alu_wb_write_ps) begin
                ps_we    = 1'b1;
                ps_wdata = alu_wb_ps;
            end
        end
    end

    // Issue stall from registered busy only; a register freed this cycle still stalls
    always_comb begin
        hazard = r_busy[src_a_addr]
               | (src_b_used & r_busy[src_b_addr])
               | w_alu_waw
               | (alu_wb_valid & ~w_alu_ready);
    end

    assign alu_wb_ready   = w_alu_ready;
    assign ld_issue_ready = w_issue_ready;
    assign outstanding    = r_count;
    assign err_underflow  = r_err;

    // Destination FIFO storage and pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                r_fifo[i] <= '0;
            end
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_tail] <= ld_issue_rd;
                r_tail         <= w_tail_nxt;
            end
            if (w_pop) begin
                r_head <= w_head_nxt;
            end
        end
    end

    // Outstanding count; push and pop together leave it unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Busy scoreboard; the pushed register is never the popped one (issue is refused
    // while the head is busy), so clear and set never collide
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            if (w_pop) begin
                r_busy[w_head_rd] <= 1'b0;
            end
            if (w_push) begin
                r_busy[ld_issue_rd] <= 1'b1;
            end
        end
    end

    // Sticky underflow flag: a response arrived with nothing outstanding
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_underflow) begin
            r_err <= 1'b1;
        end
    end

endmodule

// File: doc/wb_load_scheduler.md
Name: wb_load_scheduler

Overview:
- Owns the single register-file write port of the nand_cpu core.
- Arbitrates that port between same-cycle ALU writebacks and late, in-order data-memory load responses.
- Keeps an in-order FIFO of outstanding load destinations and a per-register busy scoreboard.
- Drives the hazard signal the core uses to stall issue. Sits between the writeback path and the register file.

Parameters:
- DATA_W, 16, register/data width
- REG_ADDR_W, 3, register address width (2**REG_ADDR_W registers)
- MAX_OUTSTANDING, 4, maximum in-flight loads; also the destination FIFO depth

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- alu_wb_valid  in  1  ALU writeback present
- alu_wb_use_rw  in  1  ALU writeback targets a register
- alu_wb_rd  in  REG_ADDR_W  ALU destination register
- alu_wb_data  in  DATA_W  ALU result
- alu_wb_write_ps  in  1  ALU writeback updates the predicate/status bit
- alu_wb_ps  in  1  new predicate value
- alu_wb_ready  out  1  ALU writeback accepted this cycle
- ld_issue  in  1  core issues a load
- ld_issue_rd  in  REG_ADDR_W  load destination register
- ld_issue_ready  out  1  load issue accepted this cycle
- ld_rsp_valid  in  1  memory returns the oldest load's data; no backpressure
- ld_rsp_data  in  DATA_W  load data
- src_a_addr  in  REG_ADDR_W  decoding instruction's ra
- src_b_addr  in  REG_ADDR_W  decoding instruction's rt
- src_b_used  in  1  rt is read (not an immediate)
- hazard  out  1  core must stall the decoding instruction
- rf_we  out  1  register-file write enable
- rf_waddr  out  REG_ADDR_W  write address
- rf_wdata  out  DATA_W  write data
- ps_we  out  1  predicate write enable
- ps_wdata  out  1  predicate write data
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  in-flight load count
- err_underflow  out  1  sticky: a response arrived with no outstanding load

Behaviour:
- State: busy[2**REG_ADDR_W], destination FIFO (head/tail pointers wrap modulo MAX_OUTSTANDING), count, err. All registered.
- Reset (asynchronous, any time, including mid-operation): busy all 0, FIFO empty, count 0, err_underflow 0. In-flight memory responses after reset are not tracked.
- Write-port outputs, hazard, alu_wb_ready and ld_issue_ready are combinational from the inputs and the registered state. There is no added latency: writes land on the same cycle.
- load_win = ld_rsp_valid & (count != 0).
  - When load_win: rf_we=1, rf_waddr=FIFO head, rf_wdata=ld_rsp_data, ps_we=0, alu_wb_ready=0.
  - Load responses always take priority.
- alu_waw = alu_wb_valid & alu_wb_use_rw & busy[alu_wb_rd].
- alu_wb_ready = ~load_win & ~alu_waw.
- When alu_wb_ready:
  - rf_we = alu_wb_valid & alu_wb_use_rw, rf_waddr = alu_wb_rd, rf_wdata = alu_wb_data.
  - ps_we = alu_wb_valid & alu_wb_write_ps, ps_wdata = alu_wb_ps.
- With nothing valid: rf_we=0, ps_we=0, rf_waddr=0, rf_wdata=0, ps_wdata=0.
- hazard = busy[src_a_addr] | (src_b_used & busy[src_b_addr]) | alu_waw | (alu_wb_valid & ~alu_wb_ready).
- hazard uses registered busy only. A register freed this cycle still hazards this cycle; there is no bypass.
- ld_issue_ready = (count < MAX_OUTSTANDING) & ~busy[ld_issue_rd]. This forbids two in-flight loads to one register.
- Accepted issue (ld_issue & ld_issue_ready): push rd at tail, set busy[rd] next cycle, count+1.
- An issue without ready is ignored. The core must hold the issue.
- load_win: pop head, clear busy[head] next cycle, count-1.
- Simultaneous accepted issue and load_win: push and pop together, count unchanged.
- An issue to the register being freed in the same cycle is refused (busy still 1).
- ld_rsp_valid with count==0: no write, no state change, err_underflow set to 1. It stays 1 until reset.
- Count never exceeds MAX_OUTSTANDING and never underflows.

Test Plan:
1. Reset, then ALU wb valid, use_rw, rd=3, data=16'h00A5, write_ps=1, ps=1 -> same cycle rf_we=1, waddr=3, wdata=00A5, ps_we=1, ps_wdata=1, alu_wb_ready=1, hazard=0.
2. Issue loads to r1, r2, r4, r5 on consecutive cycles, with a 5th to r6 -> first four accepted, outstanding=4. The r6 issue sees ld_issue_ready=0. Responses 1111, 2222, 3333, 4444 write r1, r2, r4, r5 in order, busy clears, outstanding returns to 0.
3. Load to r2 outstanding, src_a=2 -> hazard=1. Response arrives -> hazard stays 1 that cycle, drops to 0 the next cycle.
4. Same cycle: ld_rsp_valid (head r1, data BEEF) and ALU wb to r3 -> rf writes r1=BEEF, alu_wb_ready=0, hazard=1. Next cycle the ALU r3 write completes.
5. Load to r2 in flight, ALU wb to r2 -> alu_wb_ready=0, rf_we=0, hazard=1 until the response clears r2.
6. ld_rsp_valid with outstanding=0 -> rf_we=0, err_underflow=1 and sticky. Assert rst mid-burst with 3 outstanding -> outstanding=0, busy cleared, err_underflow=0 immediately (asynchronous).
